// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared defines for the EX-stage divide controller.
// Holds bus widths, divider handshake levels, the controller state
// encoding and the latched-request record.
`timescale 1ns/1ps
package div_ctrl_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  // Divider handshake levels
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DONE  = 2'b10,
    ST_DRAIN = 2'b11
  } div_state_e;

  // Operands and flags captured when a divide is accepted
  typedef struct packed {
    logic               sgn;
    logic               dbz;
    logic [REG_BUS-1:0] op1;
    logic [REG_BUS-1:0] op2;
  } div_req_t;

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: sequences DIV/DIVU between EX and the iterative divider.
// Latency: result strobe in the cycle div_ready_i rises (36 cycles, 4 for /0).
// Backpressure: stallreq_o holds the pipeline until the result is delivered.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   div_req_i, div_signed_i     EX divide request and signedness
//   op1_i, op2_i                dividend / divisor from EX
//   flush_i                     kills the EX instruction (aborts a divide)
//   div_start_o, div_annul_o    divider handshake
//   div_signed_o, div_op1_o/2_o latched request presented to the divider
//   div_result_i, div_ready_i   divider result {rem, quot} and valid
//   stallreq_o                  stall request to pipeline control
//   whilo_o, hi_o, lo_o, dbz_o  HI/LO write strobe, data and div-by-zero flag
`timescale 1ns/1ps
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      div_req_i,
  input  logic                      div_signed_i,
  input  logic [REG_BUS-1:0]        op1_i,
  input  logic [REG_BUS-1:0]        op2_i,
  input  logic                      flush_i,
  output logic                      div_start_o,
  output logic                      div_annul_o,
  output logic                      div_signed_o,
  output logic [REG_BUS-1:0]        div_op1_o,
  output logic [REG_BUS-1:0]        div_op2_o,
  input  logic [DOUBLE_REG_BUS-1:0] div_result_i,
  input  logic                      div_ready_i,
  output logic                      stallreq_o,
  output logic                      whilo_o,
  output logic [REG_BUS-1:0]        hi_o,
  output logic [REG_BUS-1:0]        lo_o,
  output logic                      dbz_o
);

  div_state_e         r_state;
  div_state_e         w_next;
  logic               r_drain_cnt;
  div_req_t           r_req;
  logic [REG_BUS-1:0] r_hi;
  logic [REG_BUS-1:0] r_lo;
  logic               r_dbz;

  logic w_accept;
  logic w_capture;

  assign w_accept  = (r_state == ST_IDLE) & div_req_i & ~flush_i;
  // A flush in the same cycle as ready wins: the instruction is dead.
  assign w_capture = (r_state == ST_BUSY) & (div_ready_i == DIV_RESULT_READY) & ~flush_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_BUSY;
      ST_BUSY: begin
        if (flush_i)        w_next = ST_DRAIN;
        else if (w_capture) w_next = ST_DONE;
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_DRAIN: if (r_drain_cnt) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    div_start_o = DIV_STOP;
    div_annul_o = 1'b0;
    stallreq_o  = 1'b0;
    whilo_o     = 1'b0;
    case (r_state)
      ST_IDLE:  stallreq_o = div_req_i & ~flush_i;
      ST_BUSY: begin
        div_start_o = DIV_START;
        div_annul_o = flush_i;
        stallreq_o  = ~w_capture;
        whilo_o     = w_capture;
      end
      // Dropping start lets the divider leave its end state; a request
      // arriving here waits for IDLE.
      ST_DONE:  stallreq_o = div_req_i;
      // Annul held for two cycles so the divider reaches free from any of
      // its on, by-zero or end states.
      ST_DRAIN: begin
        div_annul_o = 1'b1;
        stallreq_o  = div_req_i;
      end
      default: ;
    endcase
  end

  // Drain counter: zero on DRAIN entry, second DRAIN cycle sees 1
  always_ff @(posedge clk) begin
    if (rst || r_state != ST_DRAIN) r_drain_cnt <= 1'b0;
    else                            r_drain_cnt <= ~r_drain_cnt;
  end

  // Request latch: the divider re-reads operands for sign correction,
  // so they must not follow EX after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req.sgn <= div_signed_i;
      r_req.dbz <= (op2_i == ZERO_WORD);
      r_req.op1 <= op1_i;
      r_req.op2 <= op2_i;
    end
  end

  // Result hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi  <= ZERO_WORD;
      r_lo  <= ZERO_WORD;
      r_dbz <= 1'b0;
    end else if (w_capture) begin
      r_hi  <= div_result_i[DOUBLE_REG_BUS-1:REG_BUS];
      r_lo  <= div_result_i[REG_BUS-1:0];
      r_dbz <= r_req.dbz;
    end
  end

  // Data bypasses the hold registers in the strobe cycle so that
  // hi/lo/dbz are valid together with whilo_o.
  assign hi_o  = w_capture ? div_result_i[DOUBLE_REG_BUS-1:REG_BUS] : r_hi;
  assign lo_o  = w_capture ? div_result_i[REG_BUS-1:0]              : r_lo;
  assign dbz_o = w_capture ? r_req.dbz                              : r_dbz;

  assign div_signed_o = r_req.sgn;
  assign div_op1_o    = r_req.op1;
  assign div_op2_o    = r_req.op2;

endmodule

// File: tb/tb_div_ctrl.sv
`timescale 1ns/1ps
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req_i, div_signed_i, flush_i, div_ready_i;
  logic [31:0] op1_i, op2_i;
  logic [63:0] div_result_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic        stallreq_o, whilo_o, dbz_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_cnt  = 0;

  logic [31:0] last_hi = 0, last_lo = 0;
  logic        last_dbz = 0;

  div_ctrl dut (
    .clk(clk), .rst(rst),
    .div_req_i(div_req_i), .div_signed_i(div_signed_i),
    .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .stallreq_o(stallreq_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .dbz_o(dbz_o)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: {remainder, quotient}, zero for a zero divisor
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Request-to-strobe latency in cycles
  function automatic int ref_lat(input logic [31:0] b);
    return (b == 32'd0) ? 4 : 36;
  endfunction

  // One clock; also steps the divider model: counts cycles with start held
  // and annul low, raises ready after 35 (3 for /0) and holds it while start stays.
  task automatic tick();
    logic        s, a, r, sg;
    logic [31:0] o1, o2;
    s = div_start_o; a = div_annul_o; r = rst; sg = div_signed_o;
    o1 = div_op1_o; o2 = div_op2_o;
    @(posedge clk);
    #1;
    if (r || !s || a) begin
      mdl_cnt = 0; div_ready_i = 1'b0; div_result_i = 64'd0;
    end else if (!div_ready_i) begin
      mdl_cnt++;
      if (mdl_cnt >= ((o2 == 0) ? 3 : 35)) begin
        div_ready_i  = 1'b1;
        div_result_i = ref_div(o1, o2, sg);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one request at cycle 0; optional flush at cycle flush_at.
  // EX operands are scrambled after cycle 0 to prove the latch holds them.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input int flush_at,
                         output int npulse, output int pulse_cyc, output int nstall,
                         output int nannul, output int viol,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    npulse = 0; pulse_cyc = -1; nstall = 0; nannul = 0; viol = 0;
    hi = 0; lo = 0; dbz = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 0) begin
        op1_i = a; op2_i = b; div_signed_i = sg;
      end else begin
        op1_i = $urandom; op2_i = $urandom; div_signed_i = $urandom_range(1, 0);
      end
      flush_i   = (c == flush_at);
      div_req_i = (npulse == 0) && !(flush_at >= 0 && c > flush_at);
      #1;
      if (stallreq_o && npulse == 0) nstall++;
      if (div_annul_o) nannul++;
      if (whilo_o) begin
        if (flush_i) viol++;
        npulse++;
        if (npulse == 1) begin
          pulse_cyc = c; hi = hi_o; lo = lo_o; dbz = dbz_o;
        end
      end
      tick();
      if (flush_at < 0 && npulse > 0) break;
      if (flush_at >= 0 && c >= flush_at + 8) break;
    end
    flush_i = 1'b0; div_req_i = 1'b0;
  endtask

  task automatic idle_gap();
    div_req_i = 1'b0; flush_i = 1'b0;
    #1;
    tick();
  endtask

  // Full non-flushed divide with all checks against expected values
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [31:0] e_lo, input logic [31:0] e_hi, input logic e_dbz, input int e_lat);
    int np, pc, ns, na, vi;
    logic [31:0] h, l;
    logic d;
    run_div(a, b, sg, -1, np, pc, ns, na, vi, h, l, d);
    chk({tag, " pulses"}, np, 1);
    chk({tag, " latency"}, pc, e_lat);
    chk({tag, " stall_cycles"}, ns, e_lat);
    chk({tag, " lo"}, l, e_lo);
    chk({tag, " hi"}, h, e_hi);
    chk({tag, " dbz"}, d, e_dbz);
    last_hi = e_hi; last_lo = e_lo; last_dbz = e_dbz;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        sg;
    logic [31:0] e_lo, e_hi;
    logic        e_dbz;
    int          e_lat;
  } vec_t;

  vec_t vt[5];

  initial begin
    int np, pc, ns, na, vi;
    logic [31:0] h, l, a, b;
    logic d, sg;
    logic [63:0] e;
    int fa, lat;

    vt[0] = '{32'h00000064, 32'h00000007, 1'b1, 32'h0000000E, 32'h00000002, 1'b0, 36};
    vt[1] = '{32'hFFFFFF9C, 32'h00000007, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 36};
    vt[2] = '{32'hFFFFFFFF, 32'h00000010, 1'b0, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 36};
    vt[3] = '{32'h00001234, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 4};
    vt[4] = '{32'h00000007, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h00000001, 1'b0, 36};

    rst = 1'b1; div_req_i = 0; div_signed_i = 0; flush_i = 0;
    op1_i = 0; op2_i = 0; div_ready_i = 0; div_result_i = 0;
    tick(); tick();
    chk("reset start", div_start_o, 0);
    chk("reset annul", div_annul_o, 0);
    chk("reset stall", stallreq_o, 0);
    chk("reset whilo", whilo_o, 0);
    chk("reset hi_lo", {hi_o, lo_o}, 0);
    chk("reset latch", {div_signed_o, div_op1_o, div_op2_o, dbz_o}, 0);
    rst = 1'b0;
    idle_gap();

    // Table-driven divides
    for (int i = 0; i < 5; i++) begin
      do_div($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sg,
             vt[i].e_lo, vt[i].e_hi, vt[i].e_dbz, vt[i].e_lat);
      idle_gap();
    end

    // Back-to-back: second request sees DONE (stalled, start low), then full latency
    do_div("b2b_first", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0, 36);
    div_req_i = 1'b1; op1_i = 32'd81; op2_i = 32'd9; div_signed_i = 1'b1;
    #1;
    chk("b2b done_stall", stallreq_o, 1);
    chk("b2b done_start", div_start_o, 0);
    chk("b2b done_whilo", whilo_o, 0);
    tick();
    do_div("b2b_second", 32'd81, 32'd9, 1'b1, 32'd9, 32'd0, 1'b0, 36);
    idle_gap();

    // Flush in cycle 10, then DIV 9/3
    run_div(32'd1000, 32'd7, 1'b1, 10, np, pc, ns, na, vi, h, l, d);
    chk("flush pulses", np, 0);
    chk("flush annul_cycles", na, 3);
    chk("flush hi_hold", hi_o, last_hi);
    chk("flush lo_hold", lo_o, last_lo);
    do_div("after_flush", 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 36);
    idle_gap();

    // Reset asserted in cycle 20 of a divide
    div_req_i = 1'b1; op1_i = 32'd1000; op2_i = 32'd9; div_signed_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      tick();
    end
    rst = 1'b1; div_req_i = 1'b0;
    #1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid start_annul", {div_start_o, div_annul_o}, 0);
    chk("rst_mid stall_whilo", {stallreq_o, whilo_o}, 0);
    chk("rst_mid hi_lo", {hi_o, lo_o}, 0);
    chk("rst_mid latch", {div_signed_o, div_op1_o, div_op2_o, dbz_o}, 0);
    idle_gap();
    do_div("after_rst", 32'd1000, 32'd9, 1'b1, 32'd111, 32'd1, 1'b0, 36);
    idle_gap();

    // Randomized divides against the reference arithmetic, some flushed
    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      b  = ($urandom_range(4, 0) == 0) ? 32'd0 : (($urandom_range(1, 0) == 1) ? $urandom : $urandom_range(300, 1));
      sg = $urandom_range(1, 0);
      if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      lat = ref_lat(b);
      if ($urandom_range(3, 0) == 0) begin
        fa = $urandom_range(lat, 1);
        run_div(a, b, sg, fa, np, pc, ns, na, vi, h, l, d);
        chk($sformatf("rnd%0d flush_pulses", i), np, 0);
        chk($sformatf("rnd%0d flush_annul", i), na, 3);
        chk($sformatf("rnd%0d flush_hold", i), {dbz_o, hi_o, lo_o}, {last_dbz, last_hi, last_lo});
      end else begin
        e = ref_div(a, b, sg);
        do_div($sformatf("rnd%0d", i), a, b, sg, e[31:0], e[63:32], (b == 0), lat);
      end
      chk($sformatf("rnd%0d whilo_with_flush", i), vi, 0);
      idle_gap();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
